// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, operator encodings (also used by
// the ALU stage) and the keypad debounce state encoding.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } deb_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_operator(input logic [3:0] code);
        return (code >= KEY_ADD) && (code <= KEY_DIV);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Press/release debouncer for scanner key codes. accept is high during the
// cycle whose rising edge completes the stable-press run, so downstream
// registers capture the key on exactly that edge.
module key_debouncer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keyValid,
    input  logic [3:0] keyCode,
    output logic       accept,
    output logic [3:0] acceptCode
);

    localparam logic [15:0] LAST_COUNT = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic        SINGLE     = (DEBOUNCE_CYCLES == 1);

    deb_state_t  state_reg;
    logic [15:0] count_reg;
    logic [3:0]  code_reg;

    always_comb begin
        accept     = 1'b0;
        acceptCode = keyCode;
        if (state_reg == ST_IDLE && keyValid && SINGLE)
            accept = 1'b1;
        if (state_reg == ST_PRESS_WAIT && keyValid && keyCode == code_reg
            && count_reg == LAST_COUNT)
            accept = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            code_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (keyValid) begin
                        code_reg  <= keyCode;
                        count_reg <= 16'd1;
                        state_reg <= SINGLE ? ST_HELD : ST_PRESS_WAIT;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!keyValid) begin
                        state_reg <= ST_IDLE;
                    end else if (keyCode != code_reg) begin
                        // A different key restarts the stability run.
                        code_reg  <= keyCode;
                        count_reg <= 16'd1;
                    end else if (count_reg == LAST_COUNT) begin
                        state_reg <= ST_HELD;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end
                ST_HELD: begin
                    if (!keyValid) begin
                        count_reg <= 16'd1;
                        state_reg <= SINGLE ? ST_IDLE : ST_RELEASE_WAIT;
                    end
                end
                ST_RELEASE_WAIT: begin
                    // A bounce back to pressed returns to HELD without re-accepting.
                    if (keyValid)
                        state_reg <= ST_HELD;
                    else if (count_reg == LAST_COUNT)
                        state_reg <= ST_IDLE;
                    else
                        count_reg <= count_reg + 16'd1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad entry controller: debounces scanner keys, classifies them and drives
// the registered digit/operator/equals/clear strobes for the operand stage.
module key_entry_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_DIGITS      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keyValid,
    input  logic [3:0] keyCode,
    output logic [3:0] digits,
    output logic       newNumber,
    output logic [1:0] digitnumber,
    output logic       newOperation,
    output logic [1:0] opCode,
    output logic       equals,
    output logic       clearReq,
    output logic       entryFull
);

    localparam logic [2:0] DIGIT_LIMIT = 3'(MAX_DIGITS);

    logic       accept;
    logic [3:0] acceptCode;
    logic [1:0] op_from_code;

    logic [3:0] digits_reg;
    logic       new_number_reg;
    logic [1:0] digitnumber_reg;
    logic       new_operation_reg;
    logic [1:0] op_code_reg;
    logic       equals_reg;
    logic       clear_req_reg;
    logic       entry_full_reg;
    logic [2:0] cnt_reg;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .rst       (rst),
        .keyValid  (keyValid),
        .keyCode   (keyCode),
        .accept    (accept),
        .acceptCode(acceptCode)
    );

    assign op_from_code = 2'(acceptCode - KEY_ADD);

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_reg        <= '0;
            new_number_reg    <= 1'b0;
            digitnumber_reg   <= '0;
            new_operation_reg <= 1'b0;
            op_code_reg       <= '0;
            equals_reg        <= 1'b0;
            clear_req_reg     <= 1'b0;
            entry_full_reg    <= 1'b0;
            cnt_reg           <= '0;
        end else begin
            new_number_reg    <= 1'b0;
            new_operation_reg <= 1'b0;
            equals_reg        <= 1'b0;
            clear_req_reg     <= 1'b0;
            if (accept) begin
                if (is_digit(acceptCode)) begin
                    // Digits beyond the operand width are silently dropped.
                    if (cnt_reg < DIGIT_LIMIT) begin
                        new_number_reg  <= 1'b1;
                        digits_reg      <= acceptCode;
                        digitnumber_reg <= cnt_reg[1:0];
                        cnt_reg         <= cnt_reg + 3'd1;
                        entry_full_reg  <= (cnt_reg + 3'd1 == DIGIT_LIMIT);
                    end
                end else begin
                    cnt_reg        <= '0;
                    entry_full_reg <= 1'b0;
                    if (is_operator(acceptCode)) begin
                        new_operation_reg <= 1'b1;
                        op_code_reg       <= op_from_code;
                    end else if (acceptCode == KEY_EQ) begin
                        equals_reg <= 1'b1;
                    end else begin
                        clear_req_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign digits       = digits_reg;
    assign newNumber    = new_number_reg;
    assign digitnumber  = digitnumber_reg;
    assign newOperation = new_operation_reg;
    assign opCode       = op_code_reg;
    assign equals       = equals_reg;
    assign clearReq     = clear_req_reg;
    assign entryFull    = entry_full_reg;

endmodule

// File: doc/key_entry_ctrl.md
# key_entry_ctrl

Keypad entry controller for the calculator datapath, directly upstream of the operand register stage. It debounces raw key codes from the keypad scanner and classifies each accepted key as a digit, operator, equals or clear. It emits the one-cycle `newNumber` / `newOperation` strobes plus `digits` and `digitnumber`, which the operand stage consumes to build its binary and BCD operands.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive sampling edges a key must be stable, both pressed and released, before it is accepted. Legal range is 1..65535.
- `MAX_DIGITS`, default 4: digits accepted per operand. Fixed at 4 to match the 2-bit `digitnumber`.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `keyValid` in 1: scanner reports a key is pressed (level).
- `keyCode` in 4: scanner key code, meaningful while `keyValid`=1.
- `digits` out 4: accepted digit value 0..9, registered.
- `newNumber` out 1: one-cycle strobe, a digit was accepted.
- `digitnumber` out 2: position of the accepted digit, 0 for the first digit of the operand.
- `newOperation` out 1: one-cycle strobe, an operator key was accepted.
- `opCode` out 2: operator, 0 = add, 1 = sub, 2 = mul, 3 = div. Valid with `newOperation`.
- `equals` out 1: one-cycle strobe, '=' was accepted.
- `clearReq` out 1: one-cycle strobe, 'C' was accepted.
- `entryFull` out 1: level; 4 digits have been entered in the current operand.

## Operation
- Key codes:
  - 0..9 are digits.
  - 10 '+', 11 '-', 12 '*', 13 '/'.
  - 14 '='.
  - 15 'C'.
- Debounce FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE → PRESS_WAIT when `keyValid`=1. On this transition, capture `keyCode` and set the counter to 1.
  - PRESS_WAIT: while `keyValid`=1 and `keyCode` equals the captured code, the counter increments. When the counter reaches `DEBOUNCE_CYCLES`, the key is accepted and the FSM goes to HELD.
  - PRESS_WAIT: if `keyValid`=0, return to IDLE. If the code changes, recapture the new code and set the counter to 1.
  - HELD → RELEASE_WAIT when `keyValid`=0, with the counter set to 1. No key is accepted again while in HELD; there is no auto-repeat.
  - RELEASE_WAIT: `keyValid`=0 for `DEBOUNCE_CYCLES` consecutive edges → IDLE. If `keyValid`=1 during this wait → back to HELD, with no new accept.
- Digit counter `cnt`, range 0..4.
  - Accepted digit with `cnt`<4: pulse `newNumber`, set `digits` = code and `digitnumber` = `cnt`, then `cnt`++.
  - Accepted digit with `cnt`=4: ignored. No strobe is produced and outputs are unchanged.
- Accepted operator: pulse `newOperation`, set `opCode` = code−10, and clear `cnt` to 0.
- Accepted '=': pulse `equals` and clear `cnt` to 0.
- Accepted 'C': pulse `clearReq` and clear `cnt` to 0.
- `entryFull` = (`cnt`==4), registered.
- At most one strobe is asserted in any cycle.

## Timing
- Reset values:
  - All strobes 0.
  - `digits`, `digitnumber`, `opCode` = 0.
  - `entryFull` = 0, `cnt` = 0.
  - FSM in IDLE.
- Reset asserted mid-debounce or mid-hold aborts with no strobe. A key still held after reset is treated as a fresh press from IDLE.
- Latency: a key is sampled stable on N = `DEBOUNCE_CYCLES` consecutive edges. The strobe is registered at the Nth edge and is high for exactly one cycle.
- `digits`, `digitnumber` and `opCode` are updated on the same edge as their strobe and hold afterwards.
- `cnt` and `entryFull` update on the same edge as the strobe.
- `rst` takes priority over any acceptance in the same cycle.

## Structure
- Package `calc_pkg`:
  - key code localparams `KEY_ADD`, `KEY_SUB`, `KEY_MUL`, `KEY_DIV`, `KEY_EQ`, `KEY_CLR`;
  - opCode encodings;
  - the debounce FSM state encoding.
  - The same opCode encodings are shared with the ALU stage.
- Sub-module `key_debouncer`: contains the FSM and counter. It outputs `accept` (one-cycle pulse) and `acceptCode`.
- The top level holds the classifier, digit counter and output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Press code 7 held for 10 cycles, then released → exactly one `newNumber`, 4 edges after first sample, with `digits`=7 and `digitnumber`=0. No second pulse.
- Digits 1,2,3,4,5 entered as clean presses → four `newNumber` pulses with `digitnumber` 0,1,2,3. `entryFull`=1 after the 4th. Key 5 produces no strobe.
- Digits 9,8, then code 12 → `newOperation` with `opCode`=2, and `cnt` returns to 0. A following digit 6 gives `digitnumber`=0.
- Bounce: `keyValid` toggles 1,1,0,1,1,1,1 → a single accept after the final 4-high run. A code change 3→5 mid-wait accepts only 5, after 4 stable edges.
- Release bounce: after accept, `keyValid` goes 0,0,1,0,0,0,0 → no second strobe. A next press is accepted normally.
- `rst` asserted on the cycle the accept would fire → no strobe and all outputs 0. Code 15 pressed after reset → `clearReq` pulse.
